// File: rtl/output_pack_pkg.sv
// Shared definitions for the output packer: line geometry and line-buffer state.
package output_pack_pkg;

  localparam int OP_LINE_BYTES = 256;
  localparam int OP_LINE_WORDS = 32;
  localparam int TAG_W         = 24;

  typedef enum logic [1:0] {
    LS_EMPTY,
    LS_FILL,
    LS_PENDING,
    LS_DRAIN
  } line_state_e;

endpackage

// File: rtl/output_pack_if.sv
// Byte-input and burst-write signals of the output packer.
interface output_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_adr;
  logic [7:0]  in_data;
  logic        flush;
  logic        busy;
  logic        wreq;
  logic        wack;
  logic [31:0] wadr;
  logic [63:0] wdata;
  logic [7:0]  wstb;
  logic [7:0]  wlen;

  modport master (
    output in_valid, in_adr, in_data, flush, wack,
    input  in_ready, busy, wreq, wadr, wdata, wstb, wlen
  );

  modport slave (
    input  in_valid, in_adr, in_data, flush, wack,
    output in_ready, busy, wreq, wadr, wdata, wstb, wlen
  );
endinterface

// File: rtl/output_pack_outline_buf.sv
// One output line: byte-lane storage, per-byte strobes, tag and highest word written.
module outline_buf
  import output_pack_pkg::*;
#(
  parameter int LINE_WORDS = OP_LINE_WORDS,
  parameter int WW         = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             wr_en,
  input  logic [WW-1:0]    wr_word,
  input  logic [2:0]       wr_lane,
  input  logic [7:0]       wr_data,
  input  logic             set_tag,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             clr,
  input  logic [WW-1:0]    rd_ptr,
  output logic [63:0]      rd_data,
  output logic [7:0]       rd_strb,
  output logic [TAG_W-1:0] tag,
  output logic [WW-1:0]    maxword
);

  logic [7:0][7:0]            mem [LINE_WORDS];
  logic [LINE_WORDS-1:0][7:0] strb;

  // Data is qualified by strobes, so it needs no reset.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_word][wr_lane] <= wr_data;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      strb    <= '0;
      maxword <= '0;
      tag     <= '0;
    end else if (clr) begin
      strb    <= '0;
      maxword <= '0;
    end else begin
      if (wr_en) begin
        strb[wr_word][wr_lane] <= 1'b1;
        if (wr_word > maxword) maxword <= wr_word;
      end
      if (set_tag) tag <= tag_in;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign rd_strb = strb[rd_ptr];

endmodule

// File: rtl/output_pack.sv
// Packs scattered int8 output bytes into 256 B lines (two ping-pong buffers)
// and writes each closed line out as one burst of 64-bit beats.
module output_pack
  import output_pack_pkg::*;
#(
  parameter int LINE_WORDS = OP_LINE_WORDS
) (
  input  logic         clk,
  input  logic         xrst,
  output_pack_if.slave bus
);

  localparam int WW = $clog2(LINE_WORDS);

  line_state_e      st [2];
  logic             fill_sel, drain_sel;
  logic             wreq;
  logic [31:0]      wadr;
  logic [7:0]       wlen;
  logic [WW-1:0]    rdptr;

  logic [TAG_W-1:0] tag   [2];
  logic [WW-1:0]    maxw  [2];
  logic [63:0]      rdata [2];
  logic [7:0]       rstrb [2];
  logic [1:0]       wr_en, set_tag, clr;

  logic [TAG_W-1:0] in_tag;
  logic fsel, osel, fill_empty, tag_hit, other_empty, other_free, ready;
  logic acc, swap_in, flush_close, close, last_beat, pend_any, pend_sel, wr_sel;

  always_comb begin
    fsel        = fill_sel;
    osel        = ~fill_sel;
    in_tag      = bus.in_adr[31:8];
    fill_empty  = (st[fsel] == LS_EMPTY);
    tag_hit     = (tag[fsel] == in_tag);
    other_empty = (st[osel] == LS_EMPTY);
    last_beat   = wreq && bus.wack && (rdptr == wlen[WW-1:0]);
    // Let a flush close the fill line on the other line's final beat, so the
    // next burst can follow after the minimum one-cycle wreq gap.
    other_free  = other_empty || (st[osel] == LS_DRAIN && last_beat);
    ready       = !bus.flush && (fill_empty || tag_hit || other_empty);
    acc         = bus.in_valid && ready;
    swap_in     = acc && !fill_empty && !tag_hit;
    flush_close = bus.flush && (st[fsel] == LS_FILL) && other_free;
    close       = swap_in || flush_close;
    wr_sel      = swap_in ? osel : fsel;
    pend_any    = (st[0] == LS_PENDING) || (st[1] == LS_PENDING);
    pend_sel    = (st[1] == LS_PENDING);
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    assign wr_en[i]   = acc && (wr_sel == 1'(i));
    assign set_tag[i] = wr_en[i] && (st[i] == LS_EMPTY);
    assign clr[i]     = last_beat && (drain_sel == 1'(i));

    outline_buf #(.LINE_WORDS(LINE_WORDS), .WW(WW)) u_buf (
      .clk     (clk),
      .xrst    (xrst),
      .wr_en   (wr_en[i]),
      .wr_word (bus.in_adr[3 +: WW]),
      .wr_lane (bus.in_adr[2:0]),
      .wr_data (bus.in_data),
      .set_tag (set_tag[i]),
      .tag_in  (in_tag),
      .clr     (clr[i]),
      .rd_ptr  (rdptr),
      .rd_data (rdata[i]),
      .rd_strb (rstrb[i]),
      .tag     (tag[i]),
      .maxword (maxw[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      st[0]     <= LS_EMPTY;
      st[1]     <= LS_EMPTY;
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
      rdptr     <= '0;
      wreq      <= 1'b0;
      wadr      <= '0;
      wlen      <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (set_tag[i]) st[i] <= LS_FILL;
      if (close) begin
        st[fsel] <= LS_PENDING;
        fill_sel <= osel;
      end
      // At most one line is ever Pending or Drain, so close order is preserved.
      if (!wreq) begin
        if (pend_any) begin
          st[pend_sel] <= LS_DRAIN;
          drain_sel    <= pend_sel;
          wreq         <= 1'b1;
          wadr         <= {tag[pend_sel], 8'h00};
          wlen         <= 8'(maxw[pend_sel]);
          rdptr        <= '0;
        end
      end else if (bus.wack) begin
        if (last_beat) begin
          wreq          <= 1'b0;
          st[drain_sel] <= LS_EMPTY;
          rdptr         <= '0;
        end else begin
          rdptr <= rdptr + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.busy     = (st[0] != LS_EMPTY) || (st[1] != LS_EMPTY);
  assign bus.wreq     = wreq;
  assign bus.wadr     = wadr;
  assign bus.wlen     = wlen;
  assign bus.wdata    = rdata[drain_sel];
  assign bus.wstb     = wreq ? rstrb[drain_sel] : 8'h00;

endmodule

// File: tb/tb_output_pack.sv
// Bench for output_pack: per-line reference model feeding a beat scoreboard,
// a vector table of single-byte lines, and hand-written burst corner cases.
module tb_output_pack;
  import output_pack_pkg::*;

  logic clk  = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  output_pack_if bus();
  output_pack #(.LINE_WORDS(32)) dut (.clk(clk), .xrst(xrst), .bus(bus));

  typedef struct {
    logic [31:0] adr;
    logic [7:0]  len;
    int          idx;
    logic [63:0] data;
    logic [7:0]  stb;
  } beat_t;

  typedef struct {
    logic [31:0] adr;
    logic [7:0]  data;
    logic [31:0] exp_wadr;
    logic [7:0]  exp_wlen;
    logic [7:0]  exp_stb;
  } vec_t;

  // ---------------- beat monitor (sole writer of obs/obs_n/gap state)
  beat_t obs [4096];
  int    obs_n    = 0;
  int    bidx     = 0;
  int    low_cnt  = 0;
  int    last_gap = -1;
  logic  prev_wreq = 1'b0;

  always @(negedge clk) begin
    if (xrst && bus.wreq && bus.wack && obs_n < 4096) begin
      obs[obs_n] = '{bus.wadr, bus.wlen, bidx, bus.wdata, bus.wstb};
      obs_n++;
      bidx++;
    end
    if (!bus.wreq) begin
      bidx = 0;
      low_cnt++;
    end else begin
      if (!prev_wreq) last_gap = low_cnt;
      low_cnt = 0;
    end
    prev_wreq = bus.wreq;
  end

  // ---------------- arbiter model: 0 = always ack, 1 = random, 2 = hold off
  int wack_mode = 2;
  initial begin
    bus.wack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wack_mode)
        0:       bus.wack = 1'b1;
        1:       bus.wack = 1'($urandom_range(0, 1));
        default: bus.wack = 1'b0;
      endcase
    end
  end

  // ---------------- reference model and scoreboard
  int          errors = 0;
  int          checks = 0;
  beat_t       exp_q [$];
  int          rd_i = 0;
  bit          cur_open = 0;
  logic [23:0] cur_tag;
  logic [63:0] cur_data [32];
  logic [7:0]  cur_stb  [32];
  int          cur_max;
  logic [7:0]  mem_ref [bit [31:0]];
  logic [7:0]  mem_dut [bit [31:0]];
  vec_t        vt [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_close();
    if (cur_open) begin
      for (int w = 0; w <= cur_max; w++)
        exp_q.push_back('{{cur_tag, 8'h00}, 8'(cur_max), w, cur_data[w], cur_stb[w]});
      cur_open = 0;
    end
  endtask

  task automatic model_byte(input logic [31:0] a, input logic [7:0] d);
    int w, l;
    if (cur_open && a[31:8] != cur_tag) model_close();
    if (!cur_open) begin
      cur_open = 1;
      cur_tag  = a[31:8];
      cur_max  = 0;
      for (int k = 0; k < 32; k++) cur_stb[k] = 8'h00;
    end
    w = int'(a[7:3]);
    l = int'(a[2:0]);
    cur_data[w][l*8 +: 8] = d;
    cur_stb[w][l] = 1'b1;
    if (w > cur_max) cur_max = w;
    mem_ref[a] = d;
  endtask

  task automatic check_beats(input bit expect_all);
    beat_t e;
    logic [63:0] m;
    while (rd_i < obs_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_beat: got adr %0h idx %0d expected no beat", obs[rd_i].adr, obs[rd_i].idx);
      end else begin
        e = exp_q.pop_front();
        for (int l = 0; l < 8; l++) m[l*8 +: 8] = {8{e.stb[l]}};
        if (obs[rd_i].adr !== e.adr || obs[rd_i].len !== e.len || obs[rd_i].idx != e.idx ||
            obs[rd_i].stb !== e.stb || (obs[rd_i].data & m) !== (e.data & m)) begin
          errors++;
          $display("FAIL beat: got adr %0h len %0d idx %0d stb %0h data %0h expected adr %0h len %0d idx %0d stb %0h data %0h",
                   obs[rd_i].adr, obs[rd_i].len, obs[rd_i].idx, obs[rd_i].stb, obs[rd_i].data & m,
                   e.adr, e.len, e.idx, e.stb, e.data & m);
        end
      end
      for (int l = 0; l < 8; l++)
        if (obs[rd_i].stb[l])
          mem_dut[obs[rd_i].adr + 32'(obs[rd_i].idx * 8 + l)] = obs[rd_i].data[l*8 +: 8];
      rd_i++;
    end
    if (expect_all) chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_byte(input logic [31:0] a, input logic [7:0] d, input int budget, output bit ok);
    int n = 0;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_adr   = a;
    bus.in_data  = d;
    while (!ok && n < budget) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (ok) model_byte(a, d);
  endtask

  task automatic flush_idle(input string nm);
    int n = 0;
    model_close();
    bus.flush = 1'b1;
    while (bus.busy && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.flush = 1'b0;
    chk(nm, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bit ok;
    int base, nbad, n, snap;
    logic [23:0] rtag;
    logic [23:0] tags [4];
    logic [31:0] a;

    vt[0] = '{32'h0000_0000, 8'h11, 32'h0000_0000, 8'd0,  8'h01};
    vt[1] = '{32'h0000_01FF, 8'h22, 32'h0000_0100, 8'd31, 8'h80};
    vt[2] = '{32'hFFFF_FF3A, 8'h33, 32'hFFFF_FF00, 8'd7,  8'h04};
    vt[3] = '{32'h1234_5605, 8'h44, 32'h1234_5600, 8'd0,  8'h20};
    vt[4] = '{32'h0000_0AE1, 8'h55, 32'h0000_0A00, 8'd28, 8'h02};
    tags[0] = 24'h000010; tags[1] = 24'h000011; tags[2] = 24'h000012; tags[3] = 24'hABCDEF;

    bus.in_valid = 1'b0;
    bus.in_adr   = '0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1 xrst = 1'b1;
    chk("rst_wreq",     64'(bus.wreq),     64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // single-byte lines from the vector table
    wack_mode = 0;
    for (int k = 0; k < 5; k++) begin
      base = obs_n;
      send_byte(vt[k].adr, vt[k].data, 20, ok);
      chk($sformatf("vec%0d_acc", k), 64'(ok), 64'd1);
      flush_idle($sformatf("vec%0d_idle", k));
      check_beats(1);
      chk($sformatf("vec%0d_nbeats", k), 64'(obs_n - base), 64'(vt[k].exp_wlen) + 64'd1);
      if (obs_n > base) begin
        chk($sformatf("vec%0d_wadr", k), 64'(obs[base].adr), 64'(vt[k].exp_wadr));
        chk($sformatf("vec%0d_wlen", k), 64'(obs[base].len), 64'(vt[k].exp_wlen));
        chk($sformatf("vec%0d_lstb", k), 64'(obs[obs_n-1].stb), 64'(vt[k].exp_stb));
      end
    end

    // full sequential line
    base = obs_n; nbad = 0;
    for (int i = 32'h100; i < 32'h200; i++) begin
      send_byte(32'(i), 8'(i) ^ 8'h5A, 4, ok);
      if (!ok) nbad++;
    end
    chk("full_acc", 64'(nbad), 64'd0);
    flush_idle("full_idle");
    check_beats(1);
    chk("full_nbeats", 64'(obs_n - base), 64'd32);
    if (obs_n > base) chk("full_wadr", 64'(obs[base].adr), 64'h100);

    // sparse line: unwritten middle words carry zero strobes
    base = obs_n;
    send_byte(32'h203, 8'hA3, 4, ok);
    send_byte(32'h21A, 8'hBA, 4, ok);
    flush_idle("sparse_idle");
    check_beats(1);
    chk("sparse_nbeats", 64'(obs_n - base), 64'd4);
    if (obs_n >= base + 4) begin
      chk("sparse_wadr", 64'(obs[base].adr), 64'h200);
      chk("sparse_wlen", 64'(obs[base].len), 64'd3);
      chk("sparse_stb0", 64'(obs[base].stb),   64'h08);
      chk("sparse_stb1", 64'(obs[base+1].stb), 64'h00);
      chk("sparse_stb2", 64'(obs[base+2].stb), 64'h00);
      chk("sparse_stb3", 64'(obs[base+3].stb), 64'h04);
    end

    // fill during drain, stall on a third line until the drain completes
    wack_mode = 2;
    base = obs_n;
    for (int i = 0; i < 16; i++) send_byte(32'(i), 8'(i) + 8'h10, 4, ok);
    model_close();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n = 0;
    while (!bus.wreq && n < 10) begin @(posedge clk); #1; n++; end
    chk("ovl_wreq", 64'(bus.wreq), 64'd1);
    send_byte(32'h100, 8'h77, 4, ok);
    chk("ovl_acc_during_drain", 64'(ok), 64'd1);
    send_byte(32'h200, 8'h88, 8, ok);
    chk("ovl_stall", 64'(ok), 64'd0);
    wack_mode = 0;
    send_byte(32'h200, 8'h88, 50, ok);
    chk("ovl_acc_after", 64'(ok), 64'd1);
    chk("ovl_drain_done", 64'(obs_n - base), 64'd2);
    flush_idle("ovl_idle");
    check_beats(1);

    // two back-to-back full lines, continuous ack
    wack_mode = 2;
    nbad = 0;
    for (int i = 0; i < 512; i++) begin
      send_byte(32'(i), 8'(i) ^ 8'h3C, 4, ok);
      if (!ok) nbad++;
    end
    chk("b2b_acc", 64'(nbad), 64'd0);
    base = obs_n;
    wack_mode = 0;
    flush_idle("b2b_idle");
    check_beats(1);
    chk("b2b_nbeats", 64'(obs_n - base), 64'd64);
    if (obs_n >= base + 64) begin
      chk("b2b_wadr0", 64'(obs[base].adr),    64'h000);
      chk("b2b_wadr1", 64'(obs[base+32].adr), 64'h100);
    end
    chk("b2b_gap", 64'(last_gap), 64'd1);

    // random addresses and random ack gaps, compared as a memory image
    wack_mode = 1;
    mem_ref.delete();
    mem_dut.delete();
    nbad = 0;
    rtag = tags[0];
    for (int i = 0; i < 256; i++) begin
      if (i % 32 == 0) rtag = tags[$urandom_range(0, 3)];
      a = {rtag, 8'($urandom)};
      send_byte(a, 8'($urandom), 500, ok);
      if (!ok) nbad++;
    end
    chk("rnd_acc", 64'(nbad), 64'd0);
    flush_idle("rnd_idle");
    check_beats(1);
    nbad = 0;
    foreach (mem_ref[k]) if (!mem_dut.exists(k) || mem_dut[k] !== mem_ref[k]) nbad++;
    chk("rnd_mem_bad", 64'(nbad), 64'd0);
    chk("rnd_mem_size", 64'(mem_dut.size()), 64'(mem_ref.size()));

    // reset in the middle of a burst
    wack_mode = 0;
    for (int i = 32'h300; i < 32'h400; i++) send_byte(32'(i), 8'(i), 4, ok);
    base = obs_n;
    model_close();
    bus.flush = 1'b1;
    n = 0;
    while (obs_n - base < 10 && n < 500) begin @(posedge clk); #1; n++; end
    bus.flush = 1'b0;
    xrst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_beats_before", 64'(obs_n - base), 64'd10);
    chk("mrst_wreq",     64'(bus.wreq),     64'd0);
    chk("mrst_busy",     64'(bus.busy),     64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    xrst = 1'b1;
    snap = obs_n;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_more_beats", 64'(obs_n), 64'(snap));
    check_beats(0);
    exp_q.delete();
    cur_open = 0;
    base = obs_n;
    for (int i = 32'h400; i < 32'h410; i++) send_byte(32'(i), 8'(i) + 8'h01, 4, ok);
    flush_idle("mrst_new_idle");
    check_beats(1);
    chk("mrst_new_nbeats", 64'(obs_n - base), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_pack.md
OUTPUT_PACK -- requirements
Module: output_pack

Interface
REQ-001 Parameter: LINE_WORDS, default 32, number of 64-bit words per line (256 B line).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 xrst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  output byte present.
REQ-005 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-006 in_adr  input  32  byte offset of output element.
REQ-007 in_data  input  8  int8 output value.
REQ-008 flush  input  1  level; close open line and drain all.
REQ-009 busy  output  1  any line non-empty or pending.
REQ-010 wreq  output  1  burst request to arbiter.
REQ-011 wack  input  1  beat accepted by arbiter.
REQ-012 wadr  output  32  burst byte offset, {tag, 8'h00}.
REQ-013 wdata  output  64  beat data, 8 int8 lanes, lane = byte adr[2:0].
REQ-014 wstb  output  8  beat byte strobes.
REQ-015 wlen  output  8  burst length minus 1.

Function
REQ-016 Two line buffers (A, B), each: tag adr[31:8], LINE_WORDS x 64 data, LINE_WORDS x 8 strobes, maxword, state {Empty, Fill, Pending, Drain}.
REQ-017 Exactly one buffer is the fill line; accepted byte writes data[adr[7:3]] lane adr[2:0], sets its strobe bit, maxword = max(maxword, adr[7:3]); same byte rewritten: last value wins.
REQ-018 Fill line Empty: accept, tag <= in_adr[31:8], state Fill.
REQ-019 Byte with tag != fill tag: if other buffer Empty, same cycle close fill line (Pending), other becomes fill line holding this byte; else in_ready=0 until other buffer Empty.
REQ-020 flush=1 forces in_ready=0; non-empty fill line closed to Pending when other buffer not Pending/Drain.
REQ-021 busy=0 iff both buffers Empty.
REQ-022 Drain side: buffer Pending, wreq=0 -> next edge wreq=1, state Drain, wadr={tag,8'h00}, wlen=maxword, rdptr=0; lines drained in close order.
REQ-023 wadr, wlen stable while wreq=1.
REQ-024 wdata/wstb combinational from data/strobes[rdptr] of draining buffer; words never written issue wstb=0.
REQ-025 wack=1: rdptr++; wack with rdptr==wlen: wreq<=0 same edge, strobes/maxword cleared, buffer Empty.
REQ-026 wack gaps allowed; wack every cycle sustained at 1 beat/clock.
REQ-027 wreq stays low at least one cycle between bursts.
REQ-028 Draining buffer never written; fill and drain run concurrently on different buffers.
REQ-029 wack while wreq=0 ignored.

Reset
REQ-030 xrst=0 at edge: both buffers Empty, strobes cleared, fill line A, rdptr=0, wreq=0, busy=0, in_ready=1 after reset; mid-burst reset abandons burst without further beats.
REQ-031 Data array contents not reset.

Structure
REQ-032 LINE_BYTES=256, LINE_WORDS=32, line state enum in shared accelerator package.
REQ-033 One sub-module outline_buf (one line: storage, strobes, tag, maxword), instantiated twice.

Verification
REQ-034 Bytes adr 0x100..0x1FF sequential, flush -> one burst wadr=0x100, wlen=31, all wstb=0xFF, data matches.
REQ-035 Bytes adr 0x203, 0x21A only, flush -> wadr=0x200, wlen=3, beat0 wstb=0x08, beat3 wstb=0x04, beats1-2 wstb=0x00.
REQ-036 Fill 0x000 line, then byte 0x100 while line 0x000 draining with wack held 0 -> byte accepted; next byte 0x200 -> in_ready=0 until line 0x000 last wack.
REQ-037 Two pending lines, wack=1 continuously -> 32+32 beats, one-cycle wreq gap, wadr 0x000 then 0x100.
REQ-038 Random wack gaps, random byte addresses -> scoreboard memory equals reference image, no beat lost/duplicated.
REQ-039 xrst=0 at beat 10 of burst -> wreq=0, busy=0 next cycle; new stream afterwards correct.
